rho_rotate_seq: RTL and testbench
=================================

Name: rho_rotate_seq

Overview:
- Sequential, parametrised successor to the combinational Keccak rho lane-rotation step in the encoder.
- Accepts a full 25-lane state over a valid/ready handshake.
- Rotates each lane by its fixed rho offset, LANES_PER_CYC lanes per clock, then presents the result on a valid/ready output.
- Sits between theta and pi in the encoder round datapath; the lane width is generic, so it serves Keccak-f[25*LANE_W].

Parameters:
- LANE_W, 64, lane width in bits (z depth). Legal values: 8, 16, 32, 64.
- LANES_PER_CYC, 5, lanes rotated per clock. Legal values: 1, 5, 25.
- STATE_W, 25*LANE_W, derived. Never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  STATE_W  input state. Bit z of lane L=5*j+i is at index z*25+L.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  STATE_W  rotated state. Same bit layout as in_data.
- busy  output  1  high in ROT or DONE.

Behaviour:
- Rotation offsets R[L] for L=0..24: 21,8,41,45,15, 56,14,18,2,61, 28,27,0,1,62, 55,20,36,44,6, 25,39,3,10,43.
- Effective offset s = R[L] mod LANE_W.
- Output rule: out bit z of lane L = in bit ((z - s) mod LANE_W) of lane L, i.e. rotate left toward higher z. The modulus is a true non-negative modulo; never use Verilog signed % semantics.
- Storage: one internal STATE_W register holds the working state; out_data is driven directly from it.
- Lane counter: lane_idx, width clog2(25). Steps by LANES_PER_CYC.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_data into the state register, set lane_idx=0, go to ROT.
  - ROT: each cycle, rotate lanes lane_idx .. lane_idx+LANES_PER_CYC-1 in place. If this was the last group, go to DONE; otherwise lane_idx += LANES_PER_CYC.
  - DONE: out_valid=1; out_data stable and unchanged while out_ready=0. On out_ready, go to IDLE.
- Latency: accept edge to out_valid high = 25/LANES_PER_CYC cycles (25, 5 or 1). Throughput: one state per 25/LANES_PER_CYC+2 cycles. There is no overlap of input and output.
- in_ready is low in ROT and DONE. in_valid there is ignored and the input is not captured. The upstream block must hold in_valid until in_ready.
- out_ready while not in DONE is ignored.
- Reset (rst_n=0 at a clock edge, any state including mid-ROT): state=IDLE, lane_idx=0, state register=0, in_ready=0 during reset (1 on the first cycle after release), out_valid=0, busy=0. A partially rotated state is discarded.
- Lanes with s=0 pass unchanged: lane 12 always; also any lane whose R is a multiple of LANE_W.
- Illegal parameter values: elaboration fails via a generate-time check ($error).

Optional Feature:
- Macro ROTATE_INV_EN.
- Defined:
  - Adds input port in_inverse (1 bit).
  - in_inverse is captured together with in_data on accept and applies to the whole state.
  - When captured high, each lane rotates right: out bit z = in bit ((z + s) mod LANE_W). This implements inverse rho for the decoder.
  - Timing is identical to the forward mode.
- Not defined: no in_inverse port; forward rotation only.

Test Plan:
- LANE_W=64, LANES_PER_CYC=5, single bit 0 of lane 1 set -> after 5 cycles out_valid=1; only bit 8 of lane 1 set (index 8*25+1=201).
- LANE_W=64, LANES_PER_CYC=1, all-ones in_data -> out_valid exactly 25 cycles after accept; out_data all ones; in_ready=0 throughout ROT/DONE.
- LANE_W=8, LANES_PER_CYC=25, bit 0 set in lanes 2 (R=41, s=1) and 12 (R=0) -> 1-cycle latency; bit 1 of lane 2 and bit 0 of lane 12 set.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and different data -> out_data unchanged, second state accepted only after the out_ready handshake.
- Reset asserted on the 3rd ROT cycle -> the next cycle shows out_valid=0, busy=0; in_ready=1 after release; a fresh state then completes correctly.
- ROTATE_INV_EN defined: forward-rotate a random 1600-bit state, feed the result back with in_inverse=1 -> the original state is recovered bit-exact.

Source files
------------

// File: rtl/rho_rotate_seq.sv
// Sequential Keccak rho step: captures a 25-lane state, rotates LANES_PER_CYC lanes per clock in place.
// Optional macro ROTATE_INV_EN adds in_inverse for right rotation (inverse rho).
module rho_rotate_seq #(
  parameter int LANE_W        = 64,
  parameter int LANES_PER_CYC = 5,
  localparam int STATE_W      = 25 * LANE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef ROTATE_INV_EN
  input  logic               in_inverse,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  // state  | meaning
  // S_IDLE | waiting for a state on the input handshake
  // S_ROT  | rotating one lane group per clock
  // S_DONE | result held on out_data until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;

  localparam int RHO [25] = '{21,  8, 41, 45, 15,
                              56, 14, 18,  2, 61,
                              28, 27,  0,  1, 62,
                              55, 20, 36, 44,  6,
                              25, 39,  3, 10, 43};

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
    $error("rho_rotate_seq: LANE_W must be 8, 16, 32 or 64");
  end
  if (!(LANES_PER_CYC == 1 || LANES_PER_CYC == 5 || LANES_PER_CYC == 25)) begin : g_bad_lpc
    $error("rho_rotate_seq: LANES_PER_CYC must be 1, 5 or 25");
  end

  state_t             r_fsm;
  state_t             w_fsm_nxt;
  logic [4:0]         r_lane_idx;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_rot_state;
  logic               w_last;
  logic [LANE_W-1:0]  w_lane [25];
  logic [LANE_W-1:0]  w_fwd  [25];
  logic [LANE_W-1:0]  w_new  [25];
  logic [24:0]        w_sel;
`ifdef ROTATE_INV_EN
  logic               r_inverse;
  logic [LANE_W-1:0]  w_bwd  [25];
`endif

  assign w_last = ({1'b0, r_lane_idx} + 6'(LANES_PER_CYC)) >= 6'd25;

  // All offsets are elaboration constants, so each rotation is pure wiring; only the group select is live.
  for (genvar l = 0; l < 25; l++) begin : g_lane
    localparam int S = RHO[l] % LANE_W;

    assign w_sel[l] = (5'(l) >= r_lane_idx) &&
                      (({1'b0, r_lane_idx} + 6'(LANES_PER_CYC)) > 6'(l));

    for (genvar z = 0; z < LANE_W; z++) begin : g_bit
      assign w_lane[l][z] = r_state[z*25 + l];
      assign w_fwd[l][z]  = w_lane[l][(z - S + LANE_W) % LANE_W];
`ifdef ROTATE_INV_EN
      assign w_bwd[l][z]  = w_lane[l][(z + S) % LANE_W];
`endif
      assign w_rot_state[z*25 + l] = w_sel[l] ? w_new[l][z] : w_lane[l][z];
    end

`ifdef ROTATE_INV_EN
    assign w_new[l] = r_inverse ? w_bwd[l] : w_fwd[l];
`else
    assign w_new[l] = w_fwd[l];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm      <= S_IDLE;
      r_lane_idx <= '0;
      r_state    <= '0;
`ifdef ROTATE_INV_EN
      r_inverse  <= 1'b0;
`endif
    end else begin
      r_fsm <= w_fsm_nxt;
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= in_data;
            r_lane_idx <= '0;
`ifdef ROTATE_INV_EN
            r_inverse  <= in_inverse;
`endif
          end
        end
        S_ROT: begin
          r_state <= w_rot_state;
          if (!w_last) r_lane_idx <= r_lane_idx + 5'(LANES_PER_CYC);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (in_valid)  w_fsm_nxt = S_ROT;
      S_ROT:   if (w_last)    w_fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
      default:                w_fsm_nxt = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  assign in_ready  = (r_fsm == S_IDLE) && rst_n;
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_data  = r_state;

endmodule

// File: tb/tb_rho_rotate_seq.sv
// Bench for rho_rotate_seq: three parameterisations, table vectors plus handshake/reset sequences.
module tb_rho_rotate_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [2:0]    in_valid_v;
  logic [2:0]    in_ready_v;
  logic [2:0]    out_valid_v;
  logic [2:0]    busy_v;
  logic          out_ready;
  logic          inv;
  logic [1599:0] in_data;
  logic [1599:0] od0;
  logic [1599:0] od1;
  logic [199:0]  od2;

  int nchk  = 0;
  int nfail = 0;
  logic [1599:0] sb[$];

  localparam int RHO [25] = '{21,  8, 41, 45, 15,
                              56, 14, 18,  2, 61,
                              28, 27,  0,  1, 62,
                              55, 20, 36, 44,  6,
                              25, 39,  3, 10, 43};

  rho_rotate_seq #(.LANE_W(64), .LANES_PER_CYC(5)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data),
`ifdef ROTATE_INV_EN
    .in_inverse(inv),
`endif
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(od0), .busy(busy_v[0]));

  rho_rotate_seq #(.LANE_W(64), .LANES_PER_CYC(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data),
`ifdef ROTATE_INV_EN
    .in_inverse(inv),
`endif
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(od1), .busy(busy_v[1]));

  rho_rotate_seq #(.LANE_W(8), .LANES_PER_CYC(25)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data[199:0]),
`ifdef ROTATE_INV_EN
    .in_inverse(inv),
`endif
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(od2), .busy(busy_v[2]));

  function automatic logic [1599:0] get_out(input int k);
    case (k)
      0:       return od0;
      1:       return od1;
      default: return {1400'b0, od2};
    endcase
  endfunction

  // Reference: gather each lane, rotate with shifts, scatter back.
  function automatic logic [1599:0] rho_model(input logic [1599:0] d, input int lw, input bit inverse);
    logic [1599:0] r;
    logic [63:0]   v, o, mask;
    int            s;
    r = '0;
    mask = (lw == 64) ? {64{1'b1}} : ((64'd1 << lw) - 64'd1);
    for (int l = 0; l < 25; l++) begin
      v = '0;
      for (int z = 0; z < lw; z++) v[z] = d[z*25 + l];
      s = RHO[l] % lw;
      if (s == 0)        o = v;
      else if (!inverse) o = ((v << s) | (v >> (lw - s))) & mask;
      else               o = ((v >> s) | (v << (lw - s))) & mask;
      for (int z = 0; z < lw; z++) r[z*25 + l] = o[z];
    end
    return r;
  endfunction

  function automatic logic [1599:0] rand_state(input int lw);
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
    if (lw == 8) r[1599:200] = '0;
    return r;
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
    int ndiff;
    int first;
    ndiff = 0;
    first = -1;
    for (int i = 0; i < 1600; i++) begin
      if (act[i] !== exp[i]) begin
        ndiff++;
        if (first < 0) first = i;
      end
    end
    nchk++;
    if (ndiff != 0) begin
      nfail++;
      $display("FAIL %s: %0d bits differ, first at index %0d (actual %b required %b)",
               nm, ndiff, first, act[first], exp[first]);
    end
  endtask

  // Called on a negedge; returns on the negedge following the accepting posedge.
  task automatic send(input int k, input logic [1599:0] d, input logic [1599:0] exp);
    int ok;
    ok = 0;
    in_data = d;
    in_valid_v[k] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (in_ready_v[k] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk_int($sformatf("dut%0d_accept", k), ok, 1);
    if (ok == 1) begin
      @(posedge clk);
      sb.push_back(exp);
      @(negedge clk);
    end
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat, output int viol);
    lat = 0;
    viol = 0;
    while (out_valid_v[k] !== 1'b1 && lat < 200) begin
      if (in_ready_v[k] !== 1'b0 || busy_v[k] !== 1'b1) viol++;
      @(negedge clk);
      lat++;
    end
    if (in_ready_v[k] !== 1'b0 || busy_v[k] !== 1'b1) viol++;
  endtask

  task automatic recv(input int k, input string nm);
    logic [1599:0] exp;
    chk_int({nm, "_out_valid"}, int'(out_valid_v[k]), 1);
    if (sb.size() == 0) begin
      chk_int({nm, "_sb_nonempty"}, 0, 1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    chk_state({nm, "_data"}, get_out(k), exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_int({nm, "_valid_drop"}, int'(out_valid_v[k]), 0);
  endtask

  typedef struct {
    logic [1599:0] din;
    logic [1599:0] dexp;
  } vec_t;

  initial begin
    vec_t          tbl [6];
    int            lat, viol, bad;
    logic [1599:0] a, b, ea, eb, t0;

    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready = 1'b0;
    inv = 1'b0;
    in_data = '0;

    tbl[0].din = '0; tbl[0].din[1] = 1'b1;
    tbl[0].dexp = '0; tbl[0].dexp[201] = 1'b1;
    tbl[1].din = '1; tbl[1].dexp = '1;
    tbl[2].din = '0; tbl[2].din[63*25] = 1'b1;
    tbl[2].dexp = '0; tbl[2].dexp[20*25] = 1'b1;
    tbl[3].din = '0;
    for (int z = 0; z < 64; z += 3) tbl[3].din[z*25 + 12] = 1'b1;
    tbl[3].dexp = tbl[3].din;
    for (int i = 4; i < 6; i++) begin
      tbl[i].din  = rand_state(64);
      tbl[i].dexp = rho_model(tbl[i].din, 64, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk_int("rst_in_ready",  int'(in_ready_v[0]), 0);
    chk_int("rst_out_valid", int'(out_valid_v[0]), 0);
    chk_int("rst_busy",      int'(busy_v[0]), 0);
    chk_state("rst_data", od0, '0);
    rst_n = 1'b1;
    #1;
    chk_int("rel_in_ready", int'(in_ready_v[0]), 1);

    for (int i = 0; i < 6; i++) begin
      send(0, tbl[i].din, tbl[i].dexp);
      wait_out(0, lat, viol);
      chk_int($sformatf("tbl%0d_latency", i), lat, 5);
      chk_int($sformatf("tbl%0d_handshake", i), viol, 0);
      recv(0, $sformatf("tbl%0d", i));
    end

    send(1, '1, '1);
    wait_out(1, lat, viol);
    chk_int("lpc1_latency", lat, 25);
    chk_int("lpc1_handshake", viol, 0);
    recv(1, "lpc1_ones");
    a = rand_state(64);
    send(1, a, rho_model(a, 64, 1'b0));
    wait_out(1, lat, viol);
    chk_int("lpc1_rand_latency", lat, 25);
    recv(1, "lpc1_rand");

    a = '0; a[2] = 1'b1; a[12] = 1'b1;
    b = '0; b[27] = 1'b1; b[12] = 1'b1;
    send(2, a, b);
    wait_out(2, lat, viol);
    chk_int("w8_latency", lat, 1);
    chk_int("w8_handshake", viol, 0);
    recv(2, "w8_bits");
    a = rand_state(8);
    send(2, a, rho_model(a, 8, 1'b0));
    wait_out(2, lat, viol);
    chk_int("w8_rand_latency", lat, 1);
    recv(2, "w8_rand");

    a = rand_state(64); ea = rho_model(a, 64, 1'b0);
    b = rand_state(64); eb = rho_model(b, 64, 1'b0);
    send(0, a, ea);
    wait_out(0, lat, viol);
    chk_int("bp_latency", lat, 5);
    in_data = b;
    in_valid_v[0] = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (od0 !== ea || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) bad++;
    end
    chk_int("bp_hold", bad, 0);
    recv(0, "bp_first");
    chk_int("bp_ready_after", int'(in_ready_v[0]), 1);
    send(0, b, eb);
    wait_out(0, lat, viol);
    chk_int("bp_second_latency", lat, 5);
    recv(0, "bp_second");

    a = rand_state(64);
    send(0, a, rho_model(a, 64, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_int("mid_rst_out_valid", int'(out_valid_v[0]), 0);
    chk_int("mid_rst_busy",      int'(busy_v[0]), 0);
    chk_int("mid_rst_in_ready",  int'(in_ready_v[0]), 0);
    chk_state("mid_rst_data", od0, '0);
    sb.delete();
    rst_n = 1'b1;
    #1;
    chk_int("mid_rel_in_ready", int'(in_ready_v[0]), 1);
    b = rand_state(64);
    send(0, b, rho_model(b, 64, 1'b0));
    wait_out(0, lat, viol);
    chk_int("post_rst_latency", lat, 5);
    recv(0, "post_rst");

`ifdef ROTATE_INV_EN
    a = rand_state(64);
    send(0, a, rho_model(a, 64, 1'b0));
    wait_out(0, lat, viol);
    t0 = od0;
    recv(0, "inv_fwd");
    inv = 1'b1;
    send(0, t0, a);
    inv = 1'b0;
    wait_out(0, lat, viol);
    chk_int("inv_latency", lat, 5);
    recv(0, "inv_back");
`else
    t0 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
